// File: rtl/product_accumulator_if.sv
// ============================================================================
// Module      : product_accumulator_if
// Description : Product-in / frame-result-out stream bundle for
//               product_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface product_accumulator_if #(
    parameter int widthp   = 64,
    parameter int widthacc = 80,
    parameter int widthcnt = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [widthp-1:0]   in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [widthacc-1:0] out_data;
    logic [widthcnt-1:0] out_count;
    logic                overflow;

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, overflow
    );

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, overflow
    );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module      : product_accumulator
// Description : Sums a framed stream of products; emits sum and sample count
//               per frame. PRODUCT_ACCUMULATOR_SAT_EN selects saturating adds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
    parameter int widthp   = 64,
    parameter int widthacc = 80,
    parameter int widthcnt = 16,
    parameter bit us       = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clken,
    product_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state_q;
    logic [widthacc-1:0] acc_q, acc_d;
    logic [widthcnt-1:0] cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic                out_valid_q;
    logic [widthacc-1:0] out_data_q;
    logic [widthcnt-1:0] out_count_q;
    logic                overflow_q;

    logic [widthacc-1:0] ext_w;
    logic [widthacc-1:0] add_sum_w;
    logic                add_ovf_w;
    logic                in_ready_w;
    logic                accept_w;

    generate
        if (us) begin : g_ext_unsigned
            assign ext_w = widthacc'(bus.in_data);
        end else begin : g_ext_signed
            assign ext_w = widthacc'($signed(bus.in_data));
        end
    endgenerate

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    generate
        if (us) begin : g_sat_unsigned
            logic [widthacc:0] wide_w;
            assign wide_w    = {1'b0, acc_q} + {1'b0, ext_w};
            assign add_ovf_w = wide_w[widthacc];
            assign add_sum_w = add_ovf_w ? {widthacc{1'b1}} : wide_w[widthacc-1:0];
        end else begin : g_sat_signed
            logic [widthacc-1:0] raw_w;
            assign raw_w     = acc_q + ext_w;
            // Signed overflow: operands agree in sign but the result does not.
            assign add_ovf_w = (acc_q[widthacc-1] == ext_w[widthacc-1]) &&
                               (raw_w[widthacc-1] != acc_q[widthacc-1]);
            assign add_sum_w = !add_ovf_w ? raw_w :
                               acc_q[widthacc-1] ? {1'b1, {(widthacc-1){1'b0}}}
                                                 : {1'b0, {(widthacc-1){1'b1}}};
        end
    endgenerate
`else
    assign add_sum_w = acc_q + ext_w;
    assign add_ovf_w = 1'b0;
`endif

    // The only combinational input-to-output path: a held result frees the
    // input in the very cycle it is taken downstream.
    assign in_ready_w = (state_q != S_HOLD) || bus.out_ready;
    assign accept_w   = clken && bus.in_valid && in_ready_w;

    always_comb begin
        acc_d  = add_sum_w;
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + widthcnt'(1);
        flag_d = flag_q || add_ovf_w;
        if (state_q != S_ACCUM) begin
            acc_d  = ext_w;
            cnt_d  = widthcnt'(1);
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
        end else if (clken) begin
            if (state_q == S_HOLD && bus.out_ready) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
            end
            if (accept_w) begin
                acc_q  <= acc_d;
                cnt_q  <= cnt_d;
                flag_q <= flag_d;
                if (bus.in_last) begin
                    state_q     <= S_HOLD;
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_d;
                    out_count_q <= cnt_d;
                    overflow_q  <= flag_d;
                end else begin
                    state_q <= S_ACCUM;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed and random stimulus for product_accumulator against
//               an integer-arithmetic frame model (widthp=8, widthacc=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

    localparam int WP   = 8;
    localparam int WA   = 10;
    localparam int WC   = 4;
    localparam int AMAX = (1 << (WA - 1)) - 1;
    localparam int AMIN = -(1 << (WA - 1));
    localparam int CMAX = (1 << WC) - 1;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    product_accumulator_if #(.widthp(WP), .widthacc(WA), .widthcnt(WC)) bus ();

    product_accumulator #(
        .widthp(WP), .widthacc(WA), .widthcnt(WC), .us(1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame model: plain integers, a frame-open flag and a pending-result flag.
    bit m_pending, m_active, m_flag;
    int m_acc, m_cnt;
    int e_data, e_count;
    bit e_ovf;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int wrap(input int v);
        int r;
        r = v & ((1 << WA) - 1);
        if (r > AMAX) r -= (1 << WA);
        return r;
    endfunction

    function automatic int dout();
        return int'($signed(bus.out_data));
    endfunction

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic cycle(input bit v, input int d, input bit last, input bit ordy,
                         input bit ce = 1'b1, input bit rst = 1'b0);
        bit acc_ok;
        int s;
        bus.in_valid  = v;
        bus.in_data   = WP'(d);
        bus.in_last   = last;
        bus.out_ready = ordy;
        clken         = ce;
        reset         = rst;
        #1;
        chk("in_ready",  bus.in_ready, !m_pending || ordy);
        chk("out_valid", bus.out_valid, m_pending);
        if (m_pending) begin
            chk("out_data",  dout(), e_data);
            chk("out_count", bus.out_count, e_count);
            chk("overflow",  bus.overflow, e_ovf);
        end
        if (rst) begin
            m_pending = 0; m_active = 0; m_flag = 0; m_acc = 0; m_cnt = 0;
            e_data = 0; e_count = 0; e_ovf = 0;
        end else if (ce) begin
            acc_ok = v && (!m_pending || ordy);
            if (m_pending && ordy) m_pending = 0;
            if (acc_ok) begin
                if (!m_active) begin
                    m_acc = d; m_cnt = 1; m_flag = 0; m_active = 1;
                end else begin
                    s = m_acc + d;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
                    if (s > AMAX) begin s = AMAX; m_flag = 1; end
                    if (s < AMIN) begin s = AMIN; m_flag = 1; end
                    m_acc = s;
`else
                    m_acc = wrap(s);
`endif
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end
                if (last) begin
                    m_pending = 1; m_active = 0;
                    e_data = m_acc; e_count = m_cnt; e_ovf = m_flag;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
        clken = 1; reset = 1;
        m_pending = 0; m_active = 0; m_flag = 0; m_acc = 0; m_cnt = 0;
        e_data = 0; e_count = 0; e_ovf = 0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready",  bus.in_ready, 1);
        chk("rst out_data",  bus.out_data, 0);
        chk("rst out_count", bus.out_count, 0);
        chk("rst overflow",  bus.overflow, 0);

        // 3 + -5 + 7
        cycle(1, 3, 0, 1); cycle(1, -5, 0, 1); cycle(1, 7, 1, 1);
        chk("f1 out_valid", bus.out_valid, 1);
        chk("f1 out_data",  dout(), 5);
        chk("f1 out_count", bus.out_count, 3);
        chk("f1 overflow",  bus.overflow, 0);
        cycle(0, 0, 0, 1);

        // Single-sample frame.
        cycle(1, -128, 1, 1);
        chk("single out_data",  bus.out_data, 10'h380);
        chk("single out_count", bus.out_count, 1);
        cycle(0, 0, 0, 1);

        // Back-pressure in HOLD, then back-to-back frame start.
        cycle(1, 10, 0, 1); cycle(1, 20, 1, 1);
        repeat (4) cycle(1, 9, 0, 0);
        chk("hold in_ready", bus.in_ready, 0);
        chk("hold out_data", dout(), 30);
        cycle(1, 9, 0, 1); cycle(1, 1, 1, 1);
        chk("b2b out_data",  dout(), 10);
        chk("b2b out_count", bus.out_count, 2);
        cycle(0, 0, 0, 1);

        // Five products of 127.
        repeat (4) cycle(1, 127, 0, 1);
        cycle(1, 127, 1, 1);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        chk("sat out_data", dout(), 511);
        chk("sat overflow", bus.overflow, 1);
`else
        chk("wrap out_data", dout(), -389);
        chk("wrap overflow", bus.overflow, 0);
`endif
        cycle(0, 0, 0, 1);

        // clken low mid-frame.
        cycle(1, 4, 0, 1);
        repeat (3) cycle(1, 100, 0, 1, 1'b0);
        chk("ce out_valid", bus.out_valid, 0);
        cycle(1, 6, 1, 1);
        chk("ce out_data", dout(), 10);
        cycle(0, 0, 0, 1);

        // Reset mid-frame.
        cycle(1, 50, 0, 1); cycle(1, 60, 0, 1);
        cycle(0, 0, 0, 1, 1'b1, 1'b1);
        cycle(1, 1, 0, 1); cycle(1, 1, 1, 1);
        chk("rstmid out_data",  dout(), 2);
        chk("rstmid out_count", bus.out_count, 2);
        cycle(0, 0, 0, 1);

        // Counter saturation with a 4-bit count.
        repeat (19) cycle(1, 1, 0, 1);
        cycle(1, 1, 1, 1);
        chk("cntsat out_count", bus.out_count, 15);
        chk("cntsat out_data",  dout(), 20);
        cycle(0, 0, 0, 1);

        repeat (400)
            cycle($urandom_range(3) != 0, int'($urandom_range(255)) - 128,
                  $urandom_range(3) == 0, $urandom_range(3) != 0,
                  $urandom_range(7) != 0, $urandom_range(99) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
